scie_result_queue: RTL
======================

Name: scie_result_queue

Overview:
- Writeback-side stage directly downstream of SCIEPipelined.
- Tracks every accepted result-producing SCIE instruction (opcode 7'h5B) through the accelerator's fixed latency.
- Captures the complex result (io_rd_real/io_rd_imag) on the exact cycle it is valid, tags it with the destination register index, and buffers it in a small FIFO.
- Drains to the core's register writeback port with valid/ready and back-pressures issue with credit-based stall.

Parameters:
- DATA_W, 16, width of each real/imag component.
- DEPTH, 4, FIFO entries; power of two, 2..16.
- LATENCY, 1, clock edges from issue sample to valid rd on SCIE outputs; 1..4.
- TAG_W, 5, destination register tag width.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- issue_valid  in  1  instruction presented to SCIE this cycle.
- issue_insn  in  32  instruction word; opcode = issue_insn[6:0].
- issue_tag  in  TAG_W  destination register index.
- stall  out  1  issue must hold; issue is accepted only when issue_valid && !stall.
- rd_real  in  DATA_W  SCIE result, real part (signed).
- rd_imag  in  DATA_W  SCIE result, imaginary part (signed).
- wb_valid  out  1  FIFO head is valid.
- wb_ready  in  1  writeback consumer accepts the head.
- wb_tag  out  TAG_W  head tag.
- wb_data  out  2*DATA_W  head data as {imag, real}.
- occupancy  out  $clog2(DEPTH)+1  current FIFO entry count.

Behaviour:
- Reset (reset low, async): FIFO empty, tag pipe cleared, wb_valid=0, wb_tag=0, wb_data=0, occupancy=0, stall=0. Applies immediately, including mid-operation. In-flight results are discarded.
- Opcode decode:
  - 7'h0B (coefficient load) and 7'h2B (sample push) are accepted but produce no result.
  - Only 7'h5B allocates a result slot.
  - Any other opcode is accepted and ignored.
- Tag pipe: a LATENCY-stage shift register of {valid, tag}. An accepted 7'h5B enters stage 0 at the sample edge k.
- Capture: at edge k+LATENCY, rd_real/rd_imag are sampled together with the tag and pushed to the FIFO tail. The pipe is never stalled.
- Credits: in_flight = count of valid pipe stages. stall = (occupancy + in_flight >= DEPTH), computed combinationally from registered state. This guarantees a capture never finds the FIFO full.
- Drain:
  - wb_valid = (occupancy != 0).
  - wb_tag and wb_data are registered head contents.
  - Pop occurs at the edge where wb_valid && wb_ready.
  - Head data stays stable while wb_valid && !wb_ready.
- Simultaneous push and pop: occupancy unchanged, and this is legal when full.
- Push into empty FIFO: wb_valid rises the cycle after the capture edge. There is no same-cycle bypass, so minimum issue-to-wb_valid is LATENCY+1 edges.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. occupancy saturates by construction; reaching DEPTH+1 is a design error and is covered by an assertion.
- Data passes through unchanged: no sign change, no rounding.

Optional Feature:
- Macro: SCIE_RQ_STATS_EN.
- When defined, add two output ports, both cleared by reset and saturating at 16'hFFFF:
  - result_count (16): increments on every capture.
  - stall_cycles (16): increments every cycle with issue_valid && stall.
- When undefined, neither port nor counter logic exists. All other behaviour is identical.

Test Plan:
- Reset mid-drain: fill 3 entries, wb_ready=0, drop reset → wb_valid=0 and occupancy=0 immediately (before the next clock edge).
- Single result, LATENCY=1, wb_ready=1:
  - Stimulus: issue 7'h5B with tag 5'd10; one edge later drive rd_real=-750, rd_imag=1692.
  - Response: wb_valid rises the following cycle with wb_tag=10, wb_data=32'h069CFD12, then drops after one cycle.
- Non-result opcodes: issue 7'h0B ×5 then 7'h2B ×1 → no captures, wb_valid stays 0, occupancy=0.
- Back-pressure, DEPTH=4:
  - Stimulus: wb_ready=0; issue 7'h5B on 4 consecutive cycles with tags 1..4 and rd values 1235/-578, -491/-1535, -2538/-741, -3461/2856.
  - Response: stall=1 once 4 credits are used, a 5th issue is held (not accepted), occupancy=4.
  - Then wb_ready=1: pops in order, giving wb_data 32'hFDBE04D3, 32'hFA01FE15, 32'hFD1BF616, 32'h0B28F27B.
- Simultaneous push/pop at full: occupancy=4, wb_ready=1, capture arrives → occupancy stays 4, order preserved.
- Pointer wrap: 10 results streamed with tags 0..9 and wb_ready toggling 1,0,1,0... → all 10 delivered in order with matching tags, no loss or duplication.

Source files
------------

// File: rtl/scie_result_queue_if.sv
// rtl/scie_result_queue_if.sv - issue, SCIE result and writeback signals of scie_result_queue
interface scie_result_queue_if #(
  parameter int DATA_W = 16,
  parameter int TAG_W  = 5,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                     issue_valid;
  logic [31:0]              issue_insn;
  logic [TAG_W-1:0]         issue_tag;
  logic                     stall;
  logic signed [DATA_W-1:0] rd_real;
  logic signed [DATA_W-1:0] rd_imag;
  logic                     wb_valid;
  logic                     wb_ready;
  logic [TAG_W-1:0]         wb_tag;
  logic [2*DATA_W-1:0]      wb_data;
  logic [CNT_W-1:0]         occupancy;

  modport master (
    output issue_valid, issue_insn, issue_tag, rd_real, rd_imag, wb_ready,
    input  stall, wb_valid, wb_tag, wb_data, occupancy
  );

  modport slave (
    input  issue_valid, issue_insn, issue_tag, rd_real, rd_imag, wb_ready,
    output stall, wb_valid, wb_tag, wb_data, occupancy
  );
endinterface

// File: rtl/scie_result_queue.sv
// rtl/scie_result_queue.sv - SCIE result tag pipe, capture FIFO and credit stall; SCIE_RQ_STATS_EN adds counters
module scie_result_queue #(
  parameter int DATA_W  = 16,
  parameter int DEPTH   = 4,
  parameter int LATENCY = 1,
  parameter int TAG_W   = 5
) (
  input  logic               clock,
  input  logic               reset,
  scie_result_queue_if.slave bus
`ifdef SCIE_RQ_STATS_EN
  ,
  output logic [15:0]        result_count,
  output logic [15:0]        stall_cycles
`endif
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SUM_W = CNT_W + 3;
  localparam int ENT_W = TAG_W + 2*DATA_W;
  localparam logic [6:0]       OP_RESULT = 7'h5B;
  localparam logic [CNT_W-1:0] FULL      = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  logic [LATENCY-1:0] pipe_valid;
  logic [TAG_W-1:0]   pipe_tag [LATENCY];
  logic [ENT_W-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   rd_ptr_next;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_next;
  logic [SUM_W-1:0]   in_flight;
  logic [ENT_W-1:0]   push_entry;
  logic [ENT_W-1:0]   head_next;
  logic               accept;
  logic               alloc;
  logic               push;
  logic               pop;
  logic               unused_insn;

  assign unused_insn = ^bus.issue_insn[31:7];

  always_comb begin
    in_flight = '0;
    for (int i = 0; i < LATENCY; i++) begin
      in_flight = in_flight + SUM_W'(pipe_valid[i]);
    end
  end

  // Every in-flight result already owns a slot, so a capture can never meet a full FIFO.
  assign bus.stall     = (SUM_W'(count) + in_flight) >= SUM_W'(DEPTH);
  assign accept        = bus.issue_valid && !bus.stall;
  assign alloc         = accept && (bus.issue_insn[6:0] == OP_RESULT);
  assign push          = pipe_valid[LATENCY-1];
  assign pop           = bus.wb_valid && bus.wb_ready;
  assign push_entry    = {pipe_tag[LATENCY-1], bus.rd_imag, bus.rd_real};
  assign count_next    = count + CNT_W'(push) - CNT_W'(pop);
  assign rd_ptr_next   = rd_ptr + PTR_W'(pop);
  assign bus.wb_valid  = (count != '0);
  assign bus.occupancy = count;

  // The new head comes straight from the capture when that entry is not yet in memory.
  always_comb begin
    head_next = '0;
    if (count_next != '0) begin
      if (push && ((count == '0) || ((count == ONE) && pop))) begin
        head_next = push_entry;
      end else begin
        head_next = mem[rd_ptr_next];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pipe_valid  <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        pipe_tag[i] <= '0;
      end
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      bus.wb_tag  <= '0;
      bus.wb_data <= '0;
    end else begin
      pipe_valid[0] <= alloc;
      pipe_tag[0]   <= bus.issue_tag;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_tag[i]   <= pipe_tag[i-1];
      end
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      rd_ptr                  <= rd_ptr_next;
      count                   <= count_next;
      {bus.wb_tag, bus.wb_data} <= head_next;
    end
  end

  assert property (@(posedge clock) disable iff (!reset) !(push && !pop && (count == FULL)));

`ifdef SCIE_RQ_STATS_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      result_count <= '0;
      stall_cycles <= '0;
    end else begin
      if (push && (result_count != 16'hFFFF)) begin
        result_count <= result_count + 16'd1;
      end
      if (bus.issue_valid && bus.stall && (stall_cycles != 16'hFFFF)) begin
        stall_cycles <= stall_cycles + 16'd1;
      end
    end
  end
`endif
endmodule
